// File: rtl/npu_ram_tile_reader_if.sv
// Pixel stream leaving the tile reader: valid/ready handshake plus tile-position sideband.
interface npu_ram_tile_reader_if #(
  parameter int unsigned DATA_W = 8
);
  logic              px_valid;
  logic              px_ready;
  logic [DATA_W-1:0] px_data;
  logic [5:0]        px_tile_x;
  logic [5:0]        px_tile_y;
  logic [3:0]        px_row;
  logic [3:0]        px_col;
  logic              px_tile_last;
  logic              px_last;

  modport master (
    output px_valid, px_data, px_tile_x, px_tile_y, px_row, px_col, px_tile_last, px_last,
    input  px_ready
  );

  modport slave (
    input  px_valid, px_data, px_tile_x, px_tile_y, px_row, px_col, px_tile_last, px_last,
    output px_ready
  );
endinterface

// File: rtl/npu_ram_tile_reader.sv
// Tile-order read-back of the result RAM: issues port-B reads under a credit limit,
// buffers returned pixels in a small FIFO and streams them out with a per-tile checksum.
module npu_ram_tile_reader #(
  parameter int unsigned IMG_W  = 400,
  parameter int unsigned IMG_H  = 400,
  parameter int unsigned TILE   = 10,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned FIFO_D = 4
) (
  input  logic                  clk_25,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_W-1:0]     ram_q,
  npu_ram_tile_reader_if.master px,
  output logic [15:0]           tile_sum,
  output logic                  tile_sum_valid
);
  localparam int unsigned NTX   = IMG_W / TILE;
  localparam int unsigned NTY   = IMG_H / TILE;
  localparam int unsigned PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_D + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  typedef struct packed {
    logic [5:0] tx;
    logic [5:0] ty;
    logic [3:0] row;
    logic [3:0] col;
  } pos_t;

  typedef struct packed {
    logic v;
    pos_t pos;
  } pipe_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    pos_t              pos;
  } entry_t;

  state_e            state_q, state_d;
  pos_t              cur_q, cur_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  pipe_t             pipe_q [RD_LAT];
  pipe_t             pipe_d [RD_LAT];
  entry_t            fifo_q [FIFO_D];
  entry_t            fifo_d [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, inflight_q, inflight_d;
  logic [15:0]       acc_q, acc_d, tile_sum_q, tile_sum_d;
  logic              tsv_q, tsv_d;

  logic   issue_c, push_c, pop_c, last_pos_c, tile_last_c;
  entry_t head_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == FIFO_D - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_c      = fifo_q[rd_ptr_q];
  assign tile_last_c = (head_c.pos.row == 4'(TILE - 1)) && (head_c.pos.col == 4'(TILE - 1));
  assign push_c      = pipe_q[RD_LAT-1].v;
  assign pop_c       = (count_q != '0) && px.px_ready;
  assign last_pos_c  = (cur_q.tx == 6'(NTX - 1)) && (cur_q.ty == 6'(NTY - 1)) &&
                       (cur_q.row == 4'(TILE - 1)) && (cur_q.col == 4'(TILE - 1));

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    ram_addr_d = ram_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    acc_d      = acc_q;
    tile_sum_d = tile_sum_q;
    tsv_d      = 1'b0;
    issue_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse belongs to the old sweep and is dropped.
        if (start && !done_q) begin
          state_d = S_ISSUE;
          cur_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        // Issue only when the FIFO is guaranteed room for every outstanding read.
        if ((32'(count_q) + 32'(inflight_q) + 32'd1) <= FIFO_D) begin
          issue_c    = 1'b1;
          ram_addr_d = ADDR_W'((32'(cur_q.ty) * TILE + 32'(cur_q.row)) * IMG_W +
                               32'(cur_q.tx) * TILE + 32'(cur_q.col));
          if (cur_q.col != 4'(TILE - 1)) begin
            cur_d.col = cur_q.col + 4'd1;
          end else begin
            cur_d.col = '0;
            if (cur_q.row != 4'(TILE - 1)) begin
              cur_d.row = cur_q.row + 4'd1;
            end else begin
              cur_d.row = '0;
              if (cur_q.tx != 6'(NTX - 1)) begin
                cur_d.tx = cur_q.tx + 6'd1;
              end else begin
                cur_d.tx = '0;
                cur_d.ty = cur_q.ty + 6'd1;
              end
            end
          end
          if (last_pos_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_q == '0 && inflight_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sideband travels alongside the RAM read so it lines up with ram_q at the tail.
    pipe_d[0] = {issue_c, cur_q};
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    if (push_c) begin
      fifo_d[wr_ptr_q] = {ram_q, pipe_q[RD_LAT-1].pos};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    inflight_d = inflight_q + CNT_W'(issue_c) - CNT_W'(push_c);

    if (pop_c) begin
      if (tile_last_c) begin
        tile_sum_d = acc_q + 16'(head_c.data);
        tsv_d      = 1'b1;
        acc_d      = '0;
      end else begin
        acc_d = acc_q + 16'(head_c.data);
      end
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pipe_q     <= '{default: '0};
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      acc_q      <= '0;
      tile_sum_q <= '0;
      tsv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      ram_addr_q <= ram_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pipe_q     <= pipe_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      acc_q      <= acc_d;
      tile_sum_q <= tile_sum_d;
      tsv_q      <= tsv_d;
    end
  end

  // A push into a full FIFO that is not drained the same cycle means the credit rule broke.
  assert property (@(posedge clk_25) disable iff (rst)
    !(push_c && !pop_c && count_q == CNT_W'(FIFO_D)));

  assign busy           = busy_q;
  assign done           = done_q;
  assign ram_addr       = ram_addr_q;
  assign tile_sum       = tile_sum_q;
  assign tile_sum_valid = tsv_q;

  assign px.px_valid     = (count_q != '0);
  assign px.px_data      = head_c.data;
  assign px.px_tile_x    = head_c.pos.tx;
  assign px.px_tile_y    = head_c.pos.ty;
  assign px.px_row       = head_c.pos.row;
  assign px.px_col       = head_c.pos.col;
  assign px.px_tile_last = tile_last_c;
  assign px.px_last      = tile_last_c && (head_c.pos.tx == 6'(NTX - 1)) &&
                           (head_c.pos.ty == 6'(NTY - 1));
endmodule
